data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Synchronous single-port data memory answering the CPU core's data SRAM interface (`data_sram_en/we/addr/wdata` in, `data_sram_rdata` out), the responder end of the request stream the EX stage issues and the MEM stage consumes one cycle later. It holds word-addressed RAM with byte-lane writes and fixed one-cycle read latency. Optionally it decodes a small MMIO window with a free-running cycle counter and an LED register. It sits beside the CPU top in the SoC wrapper.

## Interface
- `ADDR_W`, default 16: word-index width; RAM depth 2^ADDR_W words of 32 bits.
- `clk`  in  1: single clock, rising edge.
- `resetn`  in  1: reset, asynchronous, active-low.
- `data_sram_en`  in  1: request valid this cycle.
- `data_sram_we`  in  4: byte write enables; bit i writes `wdata[8i+7:8i]`; 0 = read.
- `data_sram_addr`  in  32: byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32: write data.
- `data_sram_rdata`  out  32: response word, registered.
- `led`  out  16: LED register value (MMIO build only; constant 0 otherwise).

## Operation
- Request accepted every cycle `en`=1; no stall, no backpressure.
- Word index = `addr[ADDR_W+1:2]`; higher bits ignored for RAM (aliasing wraps).
- Read (`en`=1, `we`=0): `rdata` <= mem[index] at the edge.
- Write (`en`=1, `we`!=0): enabled bytes updated at the edge; other bytes untouched. Read-first: `rdata` <= pre-write word of same index.
- `en`=0: RAM untouched, `rdata` holds previous value.
- Back-to-back write then read of same index: read returns new data (write committed at previous edge).
- MMIO window (macro build only): `addr[31:16]`=16'hBFAF; RAM not accessed for these addresses.
  - Offset 0x0000 COUNTER: read returns counter value at the request edge; write loads counter with byte-merged wdata.
  - Offset 0x0004 LED: read returns {16'h0, led}; write updates `led` from bytes 0–1 only.
  - Other offsets: read 0, write ignored.
- Counter: +1 every cycle, wraps 0xFFFF_FFFF -> 0. Write to COUNTER same cycle as increment: written value wins; increment resumes next cycle.

## Timing
- Read latency exactly 1 cycle: request at edge N, data valid after edge N+1 through next update.
- Reset values: `rdata`=0, `led`=0, counter=0. RAM contents not reset.
- Reset asserted mid-operation: outputs go to reset values immediately (async); any write presented while `resetn`=0 is discarded, RAM and registers not modified.
- Reset release: first edge with `resetn`=1 processes request normally; counter reads 1 one cycle after a read issued at that first edge... i.e. counter value after k edges out of reset = k.

## Configuration
- `DATA_SRAM_RESP_MMIO_EN` defined: MMIO window, counter and LED register present as above.
- Undefined: no decode, all addresses go to RAM (window aliases into RAM by index), counter absent, `led` tied 0.

## Structure
- Shared package: MMIO base (16'hBFAF), offsets COUNTER=0x0000, LED=0x0004, LED width 16, data width 32.
- One sub-module natural: `data_sram_mmio_regs` (counter, LED, offset decode, read mux); instantiated only under the macro.
- RAM written as inferable array with per-byte write enable.

## Test plan
- Write 0xDEADBEEF to 0x100 with we=4'hF, read 0x100 -> rdata=0xDEADBEEF one cycle after read request.
- Over that, write 0x000000AA with we=4'b0001, read -> 0xDEADBEAA; write cycle itself returns 0xDEADBEEF (read-first).
- Alias: ADDR_W=16, write 0x1234_5678 to 0x0004_0100, read 0x0000_0100 -> 0x1234_5678.
- en=0 for 5 cycles after a read of 0xCAFEF00D -> rdata stays 0xCAFEF00D; pulse resetn low mid-cycle -> rdata=0 immediately, write during reset not committed.
- MMIO: write 0xFFFF_FFFE to 0xBFAF_0000, read next cycle -> 0xFFFF_FFFF, read after that -> 0x0000_0000 (wrap).
- MMIO: write 0x0001_A5A5 to 0xBFAF_0004 -> led=16'hA5A5, read returns 0x0000_A5A5; without macro same write lands in RAM, led stays 0.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared constants, request payload and byte-merge helper for the data SRAM responder.
package data_sram_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned LED_W  = 16;

  localparam logic [15:0] MMIO_BASE   = 16'hBFAF;
  localparam logic [15:0] OFF_COUNTER = 16'h0000;
  localparam logic [15:0] OFF_LED     = 16'h0004;

  typedef struct packed {
    logic              en;
    logic [BYTES-1:0]  we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  // Overlay the enabled byte lanes of new_w onto old_w.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BYTES-1:0]  we);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (we[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_responder_mmio_regs.sv
// MMIO window: free-running cycle counter and LED register with offset decode and read mux.
// Instantiated only when DATA_SRAM_RESP_MMIO_EN is defined.
module data_sram_mmio_regs
  import data_sram_responder_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  sram_req_t         req,
  output logic              hit_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic [LED_W-1:0]  led
);

  logic [DATA_W-1:0] counter_q, counter_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [15:0]       offset_c;
  logic              wr_c;
  logic              unused_c;

  assign hit_c    = req.en && (req.addr[31:16] == MMIO_BASE);
  assign offset_c = {req.addr[15:2], 2'b00};
  assign wr_c     = hit_c && (req.we != '0);
  assign unused_c = ^req.addr[1:0];
  assign led      = led_q;

  // A counter read returns the value the counter takes at the request edge.
  always_comb begin
    counter_d = counter_q + DATA_W'(1);
    led_d     = led_q;
    rdata_c   = '0;
    if (hit_c) begin
      case (offset_c)
        OFF_COUNTER: begin
          rdata_c = counter_q + DATA_W'(1);
          if (wr_c) counter_d = byte_merge(counter_q, req.wdata, req.we);
        end
        OFF_LED: begin
          rdata_c = DATA_W'(led_q);
          if (wr_c) led_d = LED_W'(byte_merge(DATA_W'(led_q), req.wdata, {2'b00, req.we[1:0]}));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      counter_q <= '0;
      led_q     <= '0;
    end else begin
      counter_q <= counter_d;
      led_q     <= led_d;
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Single-port word RAM with byte-lane writes, read-first, one-cycle registered read data.
// Define DATA_SRAM_RESP_MMIO_EN to add the counter/LED MMIO window at 0xBFAF_xxxx.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_en,
  input  logic [BYTES-1:0]  data_sram_we,
  input  logic [31:0]       data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic [LED_W-1:0]  led
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] idx_c;
  logic              ram_we_c;
  logic              mmio_hit_c;
  logic [DATA_W-1:0] mmio_rdata_c;
  logic              unused_c;

  assign idx_c    = data_sram_addr[ADDR_W+1:2];
  assign unused_c = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

`ifdef DATA_SRAM_RESP_MMIO_EN
  sram_req_t req_c;

  assign req_c = '{en: data_sram_en, we: data_sram_we, addr: data_sram_addr, wdata: data_sram_wdata};

  data_sram_mmio_regs u_mmio (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req_c),
    .hit_c   (mmio_hit_c),
    .rdata_c (mmio_rdata_c),
    .led     (led)
  );
`else
  assign mmio_hit_c   = 1'b0;
  assign mmio_rdata_c = '0;
  assign led          = '0;
`endif

  // Writes presented while reset is held are dropped.
  assign ram_we_c = resetn && data_sram_en && (data_sram_we != '0) && !mmio_hit_c;

  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (data_sram_we[b]) mem_q[idx_c][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (data_sram_en) rdata_d = mmio_hit_c ? mmio_rdata_c : mem_q[idx_c];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with a word-level reference model and per-cycle compare.
// Build with DATA_SRAM_RESP_MMIO_EN defined to exercise the MMIO window.
module tb_data_sram_responder;

  logic        clk    = 1'b0;
  logic        resetn = 1'b1;
  logic        en     = 1'b0;
  logic [3:0]  we     = '0;
  logic [31:0] addr   = '0;
  logic [31:0] wdata  = '0;
  logic [31:0] rdata;
  logic [15:0] led;

  int n_pass  = 0;
  int n_total = 0;

  bit [31:0] mem_m [int];
  bit [31:0] exp_rdata = '0;
  bit        exp_known = 1'b1;
  bit [15:0] exp_led   = '0;
  bit [31:0] cnt_m     = '0;

  data_sram_responder #(.ADDR_W(16)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] merge(input bit [31:0] old_w, input bit [31:0] new_w, input bit [3:0] m);
    bit [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Reference behaviour at one rising edge, from the bench's current inputs.
  task automatic model_step();
    bit [31:0] nxt_cnt;
    bit        hit;
    int        idx;
    nxt_cnt = cnt_m + 32'd1;
    if (!resetn) begin
      exp_rdata = '0; exp_known = 1'b1; exp_led = '0; cnt_m = '0;
      return;
    end
`ifdef DATA_SRAM_RESP_MMIO_EN
    hit = (addr[31:16] == 16'hBFAF);
`else
    hit = 1'b0;
`endif
    if (en) begin
      if (hit) begin
        exp_known = 1'b1;
        case (addr[15:2])
          14'd0: begin
            exp_rdata = cnt_m + 32'd1;
            if (we != 0) nxt_cnt = merge(cnt_m, wdata, we);
          end
          14'd1: begin
            exp_rdata = {16'h0, exp_led};
            if (we != 0) exp_led = 16'(merge({16'h0, exp_led}, wdata, {2'b00, we[1:0]}));
          end
          default: exp_rdata = '0;
        endcase
      end else begin
        idx = int'(addr[17:2]);
        exp_known = mem_m.exists(idx);
        if (exp_known) exp_rdata = mem_m[idx];
        if (we != 0) begin
          if (mem_m.exists(idx))  mem_m[idx] = merge(mem_m[idx], wdata, we);
          else if (we == 4'hF)    mem_m[idx] = wdata;
        end
      end
    end
    cnt_m = nxt_cnt;
  endtask

  task automatic cycle(input bit e, input bit [3:0] w, input bit [31:0] a, input bit [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check_lit(input string nm, input bit [31:0] act, input bit [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
  endtask

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (exp_known) begin
      n_total++;
      if (rdata === exp_rdata) n_pass++;
      else $display("FAIL rdata @%0t: got 0x%08h, expected 0x%08h", $time, rdata, exp_rdata);
    end
    n_total++;
    if (led === exp_led) n_pass++;
    else $display("FAIL led @%0t: got 0x%04h, expected 0x%04h", $time, led, exp_led);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 resetn = 1'b0;
    repeat (2) cycle(0, 4'h0, 32'h0, 32'h0);
    check_lit("reset_rdata", rdata, 32'h0);
    check_lit("reset_led", {16'h0, led}, 32'h0);
    resetn = 1'b1;

    cycle(1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
    cycle(1, 4'h0, 32'h0000_0100, 32'h0);
    check_lit("read_full", rdata, 32'hDEAD_BEEF);
    cycle(1, 4'h1, 32'h0000_0100, 32'h0000_00AA);
    check_lit("read_first", rdata, 32'hDEAD_BEEF);
    cycle(1, 4'h0, 32'h0000_0100, 32'h0);
    check_lit("byte_write", rdata, 32'hDEAD_BEAA);

    cycle(1, 4'hF, 32'h0004_0100, 32'h1234_5678);
    cycle(1, 4'h0, 32'h0000_0100, 32'h0);
    check_lit("alias", rdata, 32'h1234_5678);

    cycle(1, 4'hF, 32'h0000_0300, 32'h0000_0000);
    cycle(1, 4'h6, 32'h0000_0300, 32'hAABB_CCDD);
    cycle(1, 4'h8, 32'h0000_0300, 32'h1122_3344);
    cycle(1, 4'h0, 32'h0000_0300, 32'h0);
    check_lit("lane_mix", rdata, 32'h11BB_CC00);

    cycle(1, 4'hF, 32'h0000_0200, 32'hCAFE_F00D);
    cycle(1, 4'h0, 32'h0000_0200, 32'h0);
    repeat (5) cycle(0, 4'hF, 32'h0000_0200, 32'h5555_5555);
    check_lit("idle_hold", rdata, 32'hCAFE_F00D);

    #2 resetn = 1'b0;
    exp_rdata = '0; exp_known = 1'b1; exp_led = '0; cnt_m = '0;
    #1 check_lit("async_reset", rdata, 32'h0);
    cycle(1, 4'hF, 32'h0000_0200, 32'h1111_1111);
    resetn = 1'b1;
`ifdef DATA_SRAM_RESP_MMIO_EN
    cycle(1, 4'h0, 32'hBFAF_0000, 32'h0);
    check_lit("cnt_first_edge", rdata, 32'h0000_0001);
`endif
    cycle(1, 4'h0, 32'h0000_0200, 32'h0);
    check_lit("reset_write_dropped", rdata, 32'hCAFE_F00D);

`ifdef DATA_SRAM_RESP_MMIO_EN
    cycle(1, 4'hF, 32'hBFAF_0000, 32'hFFFF_FFFE);
    cycle(1, 4'h0, 32'hBFAF_0000, 32'h0);
    check_lit("cnt_max", rdata, 32'hFFFF_FFFF);
    cycle(1, 4'h0, 32'hBFAF_0000, 32'h0);
    check_lit("cnt_wrap", rdata, 32'h0000_0000);
    cycle(1, 4'hF, 32'hBFAF_0004, 32'h0001_A5A5);
    check_lit("led_reg", {16'h0, led}, 32'h0000_A5A5);
    cycle(1, 4'h0, 32'hBFAF_0004, 32'h0);
    check_lit("led_read", rdata, 32'h0000_A5A5);
    cycle(1, 4'hF, 32'hBFAF_0008, 32'h7777_7777);
    cycle(1, 4'h0, 32'hBFAF_0008, 32'h0);
    check_lit("mmio_other", rdata, 32'h0);
`else
    cycle(1, 4'hF, 32'hBFAF_0004, 32'h0001_A5A5);
    check_lit("led_tied", {16'h0, led}, 32'h0);
    cycle(1, 4'h0, 32'h0003_0004, 32'h0);
    check_lit("window_in_ram", rdata, 32'h0001_A5A5);
`endif

    repeat (2) cycle(0, 4'h0, 32'h0, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
